// File: rtl/imem_responder_pkg.sv
// Shared constants, FSM state encoding and address helpers for the instruction-memory responder.
package imem_responder_pkg;

    localparam int XLEN       = 32;
    localparam int XLEN_WIDTH = 5;

    localparam logic [XLEN-1:0] CPU_START_ADDR = 32'h0000_1000;
    localparam logic [XLEN-1:0] INST_NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_DONE = 2'd2
    } imem_state_e;

    // Unsigned subtraction makes addresses below base wrap high and fail the bound.
    function automatic logic addr_ok(input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] base,
                                     input int unsigned     depth);
        logic [XLEN-1:0] off;
        off = a - base;
        return (a[1:0] == 2'b00) && (off < (XLEN'(depth) << 2));
    endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x XLEN word array: synchronous write, asynchronous read.
// A second read port exists when IMEM_PREFETCH_EN is defined.
module imem_ram
    import imem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
`ifdef IMEM_PREFETCH_EN
    ,
    input  logic [AW-1:0]   raddr_n,
    output logic [XLEN-1:0] rdata_n
`endif
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

`ifdef IMEM_PREFETCH_EN
    assign rdata_n = mem[raddr_n];
`endif

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves a fetch after WAIT wait states, stalling until ready.
// Optional sequential-word prefetch is enabled with the IMEM_PREFETCH_EN macro.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int              DEPTH = 1024,
    parameter int              WAIT  = 2,
    parameter logic [XLEN-1:0] BASE  = CPU_START_ADDR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] data,
    output logic            stall,
    output logic            fault,
    input  logic            ld_we,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [XLEN-1:0] ld_data
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAIT);

    imem_state_e     state, state_nxt;
    logic [XLEN-1:0] lat, lat_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [XLEN-1:0] dreg, dreg_nxt;

    logic            ram_we;
    logic            ld_hits_lat;
    logic [XLEN-1:0] rdata;
    logic            pf_hit;

    assign fault       = !addr_ok(addr, BASE, DEPTH);
    assign ram_we      = ld_we && addr_ok(ld_addr, BASE, DEPTH);
    assign ld_hits_lat = ram_we && (ld_addr == lat);

`ifdef IMEM_PREFETCH_EN
    logic [XLEN-1:0] lat_next;
    logic            next_ok;
    logic            ld_hits_next;
    logic [XLEN-1:0] rdata_n;
    logic [3:0]      pcnt, pcnt_nxt;
    logic [XLEN-1:0] nbuf, nbuf_nxt;
    logic            nvld, nvld_nxt;

    assign lat_next     = lat + 32'd4;
    assign next_ok      = addr_ok(lat_next, BASE, DEPTH);
    assign ld_hits_next = ram_we && (ld_addr == lat_next);
    assign pf_hit       = (state == IMEM_DONE) && nvld && (addr == lat_next);
`else
    assign pf_hit       = 1'b0;
`endif

    imem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (AW'((ld_addr - BASE) >> 2)),
        .wdata   (ld_data),
        .raddr   (AW'((lat - BASE) >> 2)),
        .rdata   (rdata)
`ifdef IMEM_PREFETCH_EN
        ,
        .raddr_n (AW'((lat_next - BASE) >> 2)),
        .rdata_n (rdata_n)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IMEM_IDLE;
            lat   <= '0;
            cnt   <= '0;
            dreg  <= INST_NOP;
`ifdef IMEM_PREFETCH_EN
            pcnt  <= '0;
            nbuf  <= INST_NOP;
            nvld  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            lat   <= lat_nxt;
            cnt   <= cnt_nxt;
            dreg  <= dreg_nxt;
`ifdef IMEM_PREFETCH_EN
            pcnt  <= pcnt_nxt;
            nbuf  <= nbuf_nxt;
            nvld  <= nvld_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        cnt_nxt   = cnt;
        dreg_nxt  = dreg;
        if (fault) begin
            state_nxt = IMEM_IDLE;
        end else begin
            case (state)
                IMEM_IDLE: begin
                    lat_nxt   = addr;
                    cnt_nxt   = WAIT_LD;
                    state_nxt = IMEM_WAIT;
                end
                IMEM_WAIT: begin
                    if (addr != lat) begin
                        lat_nxt = addr;
                        cnt_nxt = WAIT_LD;
                    end else if (cnt == 4'd0) begin
                        // Forward a write landing on the read edge itself.
                        dreg_nxt  = ld_hits_lat ? ld_data : rdata;
                        state_nxt = IMEM_DONE;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                IMEM_DONE: begin
                    if (addr == lat) begin
                        if (ld_hits_lat) begin
                            dreg_nxt = ld_data;
                        end
                    end else if (pf_hit) begin
`ifdef IMEM_PREFETCH_EN
                        dreg_nxt = ld_hits_next ? ld_data : nbuf;
                        lat_nxt  = lat_next;
`endif
                    end else begin
                        lat_nxt   = addr;
                        cnt_nxt   = WAIT_LD;
                        state_nxt = IMEM_WAIT;
                    end
                end
                default: state_nxt = IMEM_IDLE;
            endcase
        end
    end

`ifdef IMEM_PREFETCH_EN
    // Prefetch timer runs only while parked in DONE; any other situation drops the buffer.
    always_comb begin
        pcnt_nxt = pcnt;
        nbuf_nxt = nbuf;
        nvld_nxt = nvld;
        if (fault) begin
            nvld_nxt = 1'b0;
        end else if (state == IMEM_DONE) begin
            if (addr == lat) begin
                if (!nvld) begin
                    if (pcnt != 4'd0) begin
                        pcnt_nxt = pcnt - 4'd1;
                    end else if (next_ok) begin
                        nbuf_nxt = ld_hits_next ? ld_data : rdata_n;
                        nvld_nxt = 1'b1;
                    end
                end else if (ld_hits_next) begin
                    nbuf_nxt = ld_data;
                end
            end else if (pf_hit) begin
                nvld_nxt = 1'b0;
                pcnt_nxt = WAIT_LD;
            end else begin
                nvld_nxt = 1'b0;
            end
        end else begin
            nvld_nxt = 1'b0;
            pcnt_nxt = WAIT_LD;
        end
    end

    assign data = fault ? INST_NOP : (pf_hit ? nbuf : dreg);
`else
    assign data = fault ? INST_NOP : dreg;
`endif

    assign stall = !fault && !((state == IMEM_DONE) && ((addr == lat) || pf_hit));

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: cycle table on a WAIT=2 instance plus
// hand sequences for reset abort, WAIT=0 latency and the sequential step.
module tb_imem_responder;

    localparam logic [31:0] B   = 32'h0000_1000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data, data0;
    logic        stall, stall0;
    logic        fault, fault0;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    int tests = 0;
    int fails = 0;

    imem_responder #(.DEPTH(16), .WAIT(2), .BASE(B)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .stall(stall), .fault(fault),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_responder #(.DEPTH(16), .WAIT(0), .BASE(B)) dut0 (
        .clk(clk), .rst(rst), .addr(addr), .data(data0), .stall(stall0), .fault(fault0),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        ld_we;
        logic [31:0] ld_addr;
        logic [31:0] ld_data;
        logic        exp_stall;
        logic        exp_fault;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] w(input int i);
        return (i == 0) ? 32'h0050_0093 : (32'hC0DE_0000 | 32'(i));
    endfunction

    task automatic add(input logic [31:0] a, input logic lw, input logic [31:0] la,
                       input logic [31:0] ldd, input logic es, input logic ef,
                       input logic cd, input logic [31:0] ed);
        vec_t v;
        v = '{a, lw, la, ldd, es, ef, cd, ed};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present a new address (called just after a rising edge) and count the stall
    // run of both instances from this cycle on, then check the delivered word.
    task automatic present(input logic [31:0] a, input int exp_main, input int exp0,
                           input logic [31:0] exp_data, input string name);
        int  n_main = 0;
        int  n0     = 0;
        bit  done_main = 0;
        bit  done0     = 0;
        addr = a;
        for (int c = 0; c < 40 && !(done_main && done0); c++) begin
            @(negedge clk);
            if (!done_main) begin
                if (stall) n_main++;
                else begin
                    done_main = 1;
                    chk({name, "_data"}, data, exp_data);
                end
            end
            if (!done0) begin
                if (stall0) n0++;
                else begin
                    done0 = 1;
                    chk({name, "_data_w0"}, data0, exp_data);
                end
            end
            @(posedge clk); #1;
        end
        if (!done_main || !done0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: stall never cleared (main=%0d w0=%0d)", name, done_main, done0);
        end
        chk({name, "_run"}, 32'(n_main), 32'(exp_main));
        chk({name, "_run_w0"}, 32'(n0), 32'(exp0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        addr    = B;
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = '0;

        // Cycle table for the WAIT=2 instance, one row per clock.
        repeat (4) add(B, 0, 0, 0, 1, 0, 1, NOP);
        add(B, 0, 0, 0, 0, 0, 1, w(0));
        repeat (2) add(B + 8, 0, 0, 0, 1, 0, 1, w(0));
        repeat (4) add(B + 16, 0, 0, 0, 1, 0, 1, w(0));
        add(B + 16, 0, 0, 0, 0, 0, 1, w(4));
        add(B + 2,  0, 0, 0, 0, 1, 1, NOP);
        add(B + 64, 0, 0, 0, 0, 1, 1, NOP);
        add(B - 4,  0, 0, 0, 0, 1, 1, NOP);
        repeat (4) add(B + 12, 0, 0, 0, 1, 0, 0, 0);
        add(B + 12, 0, 0, 0, 0, 0, 1, w(3));
        add(B + 12, 1, B + 12, 32'hDEAD_BEEF, 0, 0, 1, w(3));
        add(B + 12, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        add(B + 12, 1, B + 64, 32'h0000_BAD0, 0, 0, 1, 32'hDEAD_BEEF);
        add(B + 12, 1, B + 1,  32'h0000_BAD1, 0, 0, 1, 32'hDEAD_BEEF);
        repeat (4) add(B, 0, 0, 0, 1, 0, 1, 32'hDEAD_BEEF);
        add(B, 0, 0, 0, 0, 0, 1, w(0));
        add(B + 20, 0, 0, 0, 1, 0, 1, w(0));
        add(B + 20, 1, B + 20, 32'h1234_5678, 1, 0, 1, w(0));
        repeat (2) add(B + 20, 0, 0, 0, 1, 0, 1, w(0));
        add(B + 20, 0, 0, 0, 0, 0, 1, 32'h1234_5678);

        // Preload through the load port while held in reset.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            ld_we   = 1'b1;
            ld_addr = B + 32'(4 * i);
            ld_data = w(i);
        end
        @(posedge clk); #1;
        ld_we = 1'b0;

        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd1);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_data", data, NOP);
        addr = B - 4;
        #1;
        chk("rst_below_fault", {31'b0, fault}, 32'd1);
        chk("rst_below_stall", {31'b0, stall}, 32'd0);
        addr = B;
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            addr    = vecs[i].addr;
            ld_we   = vecs[i].ld_we;
            ld_addr = vecs[i].ld_addr;
            ld_data = vecs[i].ld_data;
            @(negedge clk);
            chk($sformatf("row%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].exp_stall});
            chk($sformatf("row%0d_fault", i), {31'b0, fault}, {31'b0, vecs[i].exp_fault});
            if (vecs[i].chk_data)
                chk($sformatf("row%0d_data", i), data, vecs[i].exp_data);
            @(posedge clk); #1;
        end
        ld_we = 1'b0;

        // Reset mid-access aborts the fetch but keeps the array.
        addr = B + 24;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_stall", {31'b0, stall}, 32'd1);
        chk("midrst_data", data, NOP);
        @(posedge clk); #1;
        rst = 1'b0;
        present(B + 24, 4, 2, w(6), "after_rst");

        present(B + 28, 4, 2, w(7), "miss_w0");
        present(B, 4, 2, w(0), "back_to_base");
        repeat (3) begin
            @(posedge clk); #1;
        end
`ifdef IMEM_PREFETCH_EN
        present(B + 4, 0, 0, w(1), "seq_step");
`else
        present(B + 4, 4, 2, w(1), "seq_step");
`endif
        present(B + 40, 4, 2, w(10), "jump");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
